// File: rtl/float_accumulator.sv
// Streaming FP32 burst reducer around an external combinational adder.
// Handles zero operands and exact cancellation the adder does not.
module float_accumulator #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf,
  output logic [31:0]      add_a,
  output logic [31:0]      add_b,
  input  logic [31:0]      add_y
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ACC   = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [31:0]      acc_q, acc_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;

  logic acc_hs;
  logic in_zero;
  logic acc_zero;
  logic cancel;

  assign add_a = acc_q;
  assign add_b = in_data;

  assign in_zero  = (in_data[30:23] == 8'h00);
  assign acc_zero = (acc_q[30:23] == 8'h00);
  assign cancel   = (acc_q[30:0] == in_data[30:0]) &&
                    (acc_q[31] != in_data[31]);

  // Handshakes, next-state and accumulator update selection.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    count_d   = count_q;
    ovf_d     = ovf_q;
    in_ready  = (state_q != DONE);
    acc_hs    = in_valid && in_ready;
    out_valid = 1'b0;
    out_data  = 32'h0;
    out_count = '0;
    out_ovf   = 1'b0;

    unique case (state_q)
      EMPTY: begin
        if (acc_hs) begin
          acc_d   = in_zero ? 32'h0 : in_data;
          count_d = CNT_ONE;
          state_d = in_last ? DONE : ACC;
        end
      end
      ACC: begin
        if (acc_hs) begin
          if (in_zero) begin
            acc_d = acc_q;
          end else if (acc_zero) begin
            acc_d = in_data;
          end else if (cancel) begin
            acc_d = 32'h0;
          end else begin
            acc_d = add_y;
            ovf_d = ovf_q | (add_y[30:23] == 8'hFF);
          end
          count_d = (count_q == CNT_MAX) ? count_q : count_q + CNT_ONE;
          state_d = in_last ? DONE : ACC;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        out_data  = acc_q;
        out_count = count_q;
        out_ovf   = ovf_q;
        if (out_ready) begin
          state_d = EMPTY;
          acc_d   = 32'h0;
          count_d = '0;
          ovf_d   = 1'b0;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase

    if (clear) begin
      state_d = EMPTY;
      acc_d   = 32'h0;
      count_d = '0;
      ovf_d   = 1'b0;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= EMPTY;
      acc_q   <= 32'h0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_float_accumulator.sv
// Directed bench for float_accumulator.
// Supplies a behavioural truncating FP32 adder on add_a/add_b.
module tb_float_accumulator;

  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             clear;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_data;
  logic [CNT_W-1:0] out_count;
  logic             out_ovf;
  logic [31:0]      add_a;
  logic [31:0]      add_b;
  logic [31:0]      add_y;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  float_accumulator #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count),
    .out_ovf   (out_ovf),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_y     (add_y)
  );

  function automatic logic [31:0] fp_add(
    input logic [31:0] a,
    input logic [31:0] b
  );
    logic [31:0] x, y;
    logic [24:0] mx, my, m;
    int          ex, ey, e, d;
    logic        s;
    if (a[30:23] == 8'h00) return (b[30:23] == 8'h00) ? 32'h0 : b;
    if (b[30:23] == 8'h00) return a;
    if (b[30:0] > a[30:0]) begin
      x = b; y = a;
    end else begin
      x = a; y = b;
    end
    s  = x[31];
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    mx = {2'b01, x[22:0]};
    my = {2'b01, y[22:0]};
    d  = ex - ey;
    my = (d > 24) ? 25'h0 : (my >> d);
    e  = ex;
    if (x[31] == y[31]) begin
      m = mx + my;
      if (m[24]) begin
        m = m >> 1;
        e = e + 1;
      end
    end else begin
      m = mx - my;
      if (m == 25'h0) return 32'h0;
      for (int i = 0; i < 24; i++) begin
        if (!m[23]) begin
          m = m << 1;
          e = e - 1;
        end
      end
      if (e <= 0) return 32'h0;
    end
    if (e >= 255) return {s, 8'hFF, 23'h0};
    return {s, e[7:0], m[22:0]};
  endfunction

  always_comb add_y = fp_add(add_a, add_b);

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [31:0] d, input logic last);
    int n;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("push_timeout", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic take(
    input string       tag,
    input logic [31:0] d,
    input int          cnt,
    input logic        ovf
  );
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_data"}, out_data, d);
    check({tag, "_count"}, 32'(out_count), 32'(cnt));
    check({tag, "_ovf"}, 32'(out_ovf), 32'(ovf));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_drain"}, 32'(out_valid), 32'd0);
    check({tag, "_rdy"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    reset_n   = 1'b0;
    clear     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 32'h0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", out_data, 32'h0);
    check("rst_out_count", 32'(out_count), 32'd0);
    check("rst_out_ovf", 32'(out_ovf), 32'd0);
    check("rst_add_a", add_a, 32'h0);

    push(32'h3F800000, 1'b0);
    check("basic_mid_valid", 32'(out_valid), 32'd0);
    push(32'h40000000, 1'b1);
    take("basic", 32'h40400000, 2, 1'b0);

    push(32'h40490FDB, 1'b1);
    take("single", 32'h40490FDB, 1, 1'b0);

    push(32'h3FC00000, 1'b0);
    push(32'hBFC00000, 1'b0);
    check("cancel_acc", add_a, 32'h0);
    push(32'h40000000, 1'b1);
    take("cancel", 32'h40000000, 3, 1'b0);

    push(32'h3F800000, 1'b1);
    in_valid = 1'b1;
    in_data  = 32'h40000000;
    in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_data", out_data, 32'h3F800000);
      check("bp_valid", 32'(out_valid), 32'd1);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_empty_rdy", 32'(in_ready), 32'd1);
    check("bp_empty_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    take("bp_next", 32'h40000000, 1, 1'b0);

    push(32'h7F7FFFFF, 1'b0);
    push(32'h7F7FFFFF, 1'b1);
    take("ovf", 32'h7F800000, 2, 1'b1);

    push(32'h3F800000, 1'b0);
    push(32'h40000000, 1'b0);
    in_valid = 1'b1;
    in_data  = 32'h40400000;
    clear    = 1'b1;
    @(negedge clk);
    clear    = 1'b0;
    in_valid = 1'b0;
    check("clr_valid", 32'(out_valid), 32'd0);
    check("clr_rdy", 32'(in_ready), 32'd1);
    check("clr_acc", add_a, 32'h0);
    push(32'h3F800000, 1'b0);
    push(32'h3F800000, 1'b1);
    take("clr_new", 32'h40000000, 2, 1'b0);

    push(32'h3F800000, 1'b0);
    push(32'h40000000, 1'b0);
    in_valid = 1'b1;
    in_data  = 32'h40400000;
    clear    = 1'b1;
    reset_n  = 1'b0;
    @(negedge clk);
    clear    = 1'b0;
    reset_n  = 1'b1;
    in_valid = 1'b0;
    check("rstb_valid", 32'(out_valid), 32'd0);
    check("rstb_acc", add_a, 32'h0);
    push(32'h3F800000, 1'b0);
    push(32'h3F800000, 1'b1);
    take("rstb_new", 32'h40000000, 2, 1'b0);

    for (int i = 0; i < 259; i++) push(32'h00000000, 1'b0);
    push(32'h00000001, 1'b1);
    take("sat", 32'h0, 255, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
